// File: rtl/timer_display_pkg.sv
// rtl/timer_display_pkg.sv - shared constants, segment table and BCD helper for timer_display
package timer_display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}, entry 9 first so SEG_TABLE[d] selects digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [2:0] IDX_SEP_P1 = 3'd6;
    localparam logic [2:0] IDX_SEP_P2 = 3'd2;

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [6:0] c;
        c = (v > 8'd99) ? 7'd99 : v[6:0];
        return {4'(c / 7'd10), 4'(c % 7'd10)};
    endfunction

endpackage

// File: rtl/timer_display_seg7_decode.sv
// rtl/timer_display_seg7_decode.sv - combinational BCD to active-low 7-segment decoder
module seg7_decode
    import timer_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/timer_display.sv
// rtl/timer_display.sv - snapshot, scan and drive the 8-digit chess-clock display
// Optional FLASH_ZERO_EN: blinks a player's digits while their snapshot reads 00:00.
module timer_display
    import timer_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
`ifdef FLASH_ZERO_EN
    ,
    parameter int BLINK_DIV = 25000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] min1,
    input  logic [7:0] sec1,
    input  logic [7:0] min2,
    input  logic [7:0] sec2,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int REF_W = $clog2(REFRESH_DIV + 1);

    logic [REF_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             lit_q, lit_d;
    logic [7:0]       min1_q, min1_d, sec1_q, sec1_d;
    logic [7:0]       min2_q, min2_d, sec2_q, sec2_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic [7:0]       min1_bcd, sec1_bcd, min2_bcd, sec2_bcd;
    logic [3:0]       digit;
    logic [6:0]       seg_dec;
    logic             blank;

    always_comb begin
        tick  = (cnt_q == REF_W'(REFRESH_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 3'd1 : idx_q;
        lit_d = lit_q | tick;

        // Capture all four values together on the frame wrap so a frame never tears.
        min1_d = min1_q;
        sec1_d = sec1_q;
        min2_d = min2_q;
        sec2_d = sec2_q;
        if (tick && idx_q == 3'd7) begin
            min1_d = min1;
            sec1_d = sec1;
            min2_d = min2;
            sec2_d = sec2;
        end

        min1_bcd = to_bcd(min1_d);
        sec1_bcd = to_bcd(sec1_d);
        min2_bcd = to_bcd(min2_d);
        sec2_bcd = to_bcd(sec2_d);

        case (idx_d)
            3'd7:    digit = min1_bcd[7:4];
            3'd6:    digit = min1_bcd[3:0];
            3'd5:    digit = sec1_bcd[7:4];
            3'd4:    digit = sec1_bcd[3:0];
            3'd3:    digit = min2_bcd[7:4];
            3'd2:    digit = min2_bcd[3:0];
            3'd1:    digit = sec2_bcd[7:4];
            default: digit = sec2_bcd[3:0];
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd (digit),
        .seg (seg_dec)
    );

`ifdef FLASH_ZERO_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               blink_wrap;

    always_comb begin
        blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        phase_d     = blink_wrap ? ~phase_q : phase_q;
        blank       = !phase_d && (idx_d[2] ? (min1_d == 8'd0 && sec1_d == 8'd0)
                                            : (min2_d == 8'd0 && sec2_d == 8'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Outputs are computed from the next-state index so anode, segment and dp move together.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (lit_d) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_d);
            seg_d = seg_dec;
            dp_d  = !(idx_d == IDX_SEP_P1 || idx_d == IDX_SEP_P2);
            if (blank) begin
                an_d = 8'hFF;
                dp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            lit_q  <= 1'b0;
            min1_q <= 8'd0;
            sec1_q <= 8'd0;
            min2_q <= 8'd0;
            sec2_q <= 8'd0;
            an_q   <= 8'hFF;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            lit_q  <= lit_d;
            min1_q <= min1_d;
            sec1_q <= sec1_d;
            min2_q <= min2_d;
            sec2_q <= sec2_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_timer_display.sv
// tb/tb_timer_display.sv - directed self-checking bench for timer_display (REFRESH_DIV=4)
module tb_timer_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] min1, sec1, min2, sec2;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    always #5 clk = ~clk;

    timer_display #(
        .REFRESH_DIV (4)
`ifdef FLASH_ZERO_EN
        ,
        .BLINK_DIV   (8)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .min1  (min1),
        .sec1  (sec1),
        .min2  (min2),
        .sec2  (sec2),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input logic [7:0] ea, input logic [6:0] es, input logic ed);
        check({tag, ".an"}, an, ea);
        check({tag, ".seg"}, {1'b0, seg}, {1'b0, es});
        check({tag, ".dp"}, {7'd0, dp}, {7'd0, ed});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        t += n;
    endtask

    task automatic goto(input int tt);
        step(tt - t);
    endtask

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S9 = 7'h10;

    logic [7:0] exp_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] exp_seg [8] = '{S9, S5, S5, S0, S4, S3, S2, S1};
    logic       exp_dp  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        reset = 1'b1;
        min1 = 8'd12; sec1 = 8'd34; min2 = 8'd5; sec2 = 8'd59;
        step(3);
        check_out("reset_hold", 8'hFF, 7'h7F, 1'b1);
        reset = 1'b0;
        t = 0;
        step(3);
        check_out("pre_tick", 8'hFF, 7'h7F, 1'b1);
        step(1);
        check_out("first_tick", 8'hFD, S0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            goto(32 + 4 * i);
            check_out($sformatf("scan%0d", i), exp_an[i], exp_seg[i], exp_dp[i]);
        end

        sec1 = 8'd0;
        min2 = 8'd150;
        goto(72);
        check_out("clamp_ones", 8'hFB, S9, 1'b0);
        goto(76);
        check_out("clamp_tens", 8'hF7, S9, 1'b1);
        sec1 = 8'd59;
        goto(80);
        check_out("coherent4", 8'hEF, S0, 1'b1);
        goto(84);
        check_out("coherent5", 8'hDF, S0, 1'b1);
        goto(112);
        check_out("updated4", 8'hEF, S9, 1'b1);
        goto(116);
        check_out("updated5", 8'hDF, S5, 1'b1);

        reset = 1'b1;
        step(1);
        check_out("mid_reset", 8'hFF, 7'h7F, 1'b1);
        min1 = 8'd0;
        sec1 = 8'd0;
        reset = 1'b0;
        t = 0;
        step(3);
        check_out("mid_dark", 8'hFF, 7'h7F, 1'b1);
        step(1);
        check_out("restart", 8'hFD, S0, 1'b1);

        goto(32);
        check_out("p2_idx0", 8'hFE, S9, 1'b1);
        goto(40);
        check_out("p2_idx2", 8'hFB, S9, 1'b0);
        goto(48);
        check_out("p1_idx4_on", 8'hEF, S0, 1'b1);
`ifdef FLASH_ZERO_EN
        goto(56);
        check_out("p1_idx6_off", 8'hFF, S0, 1'b1);
        goto(60);
        check_out("p1_idx7_off", 8'hFF, S0, 1'b1);
        goto(80);
        check_out("p1_idx4_on2", 8'hEF, S0, 1'b1);
        goto(88);
        check_out("p1_idx6_off2", 8'hFF, S0, 1'b1);
`else
        goto(56);
        check_out("p1_idx6", 8'hBF, S0, 1'b0);
        goto(60);
        check_out("p1_idx7", 8'h7F, S0, 1'b1);
        goto(80);
        check_out("p1_idx4b", 8'hEF, S0, 1'b1);
        goto(88);
        check_out("p1_idx6b", 8'hBF, S0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
